// File: rtl/div_pkg.sv
// Shared definitions for the sequential arithmetic units (divider today, multiplier later).
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvs_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    localparam int RW = WIDTH + 1;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvs_ext;

    always_comb begin
        shifted = {rem_i, bit_i};
        dvs_ext = {2'b00, dvs_i};
        q_o     = (shifted >= dvs_ext);
        rem_o   = q_o ? RW'(shifted - dvs_ext) : RW'(shifted);
    end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider (signed/unsigned), one quotient bit per cycle,
// sign fixup in a final cycle; remainder on hi, quotient on lo.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic             abort,
    input  logic [WIDTH-1:0] value_A,
    input  logic [WIDTH-1:0] value_B,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    a_neg;
    logic                    b_neg;
    logic [WIDTH:0]          step_rem;
    logic                    step_q;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    assign a_s = value_A;
    assign b_s = value_B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dvs_i (dvs_q),
        .bit_i (dvd_q[WIDTH-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        a_neg   = signed_op && (a_s < 0);
        b_neg   = signed_op && (b_s < 0);

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (value_B == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        dvd_d   = neg_if(value_A, a_neg);
                        dvs_d   = neg_if(value_B, b_neg);
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        cnt_d   = CNT_W'(WIDTH);
                        rem_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Quotient bits shift into the dividend register as dividend bits leave it;
                // once the counter hits zero one settle cycle remains before FIX.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!abort) begin
                    hi_d   = neg_if(WIDTH'(rem_q), r_neg_q);
                    lo_d   = neg_if(dvd_q, q_neg_q);
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign divZero = dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: 32-bit and 8-bit instances against an arithmetic model.
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        start, signed_op, abort;
    logic [31:0] value_A, value_B;
    logic        busy, done, divZero;
    logic [31:0] hi, lo;

    logic        s8_start, s8_signed_op, s8_abort;
    logic [7:0]  s8_A, s8_B;
    logic        s8_busy, s8_done, s8_divZero;
    logic [7:0]  s8_hi, s8_lo;

    int vectors    = 0;
    int miscompares = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op), .abort(abort),
        .value_A(value_A), .value_B(value_B), .busy(busy), .done(done),
        .divZero(divZero), .hi(hi), .lo(lo)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(s8_start), .signed_op(s8_signed_op), .abort(s8_abort),
        .value_A(s8_A), .value_B(s8_B), .busy(s8_busy), .done(s8_done),
        .divZero(s8_divZero), .hi(s8_hi), .lo(s8_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: language division on 64-bit values; truncates toward zero, remainder follows dividend.
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input int w,
                                    input bit sgn, output logic [63:0] q, output logic [63:0] r);
        logic [63:0] m;
        longint      sa, sb;
        m = (64'd1 << w) - 64'd1;
        if (sgn) begin
            sa = a[w-1] ? longint'(a | ~m) : longint'(a & m);
            sb = b[w-1] ? longint'(b | ~m) : longint'(b & m);
            q  = 64'(sa / sb) & m;
            r  = 64'(sa % sb) & m;
        end else begin
            q = ((a & m) / (b & m)) & m;
            r = ((a & m) % (b & m)) & m;
        end
    endfunction

    // Launch one operation and wait (bounded) for done; lat = edges from sampling edge to done.
    task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit sgn,
                          output int lat, output logic [31:0] q, output logic [31:0] r);
        @(posedge clk); #1;
        if (w8) begin
            s8_start = 1'b1; s8_A = a[7:0]; s8_B = b[7:0]; s8_signed_op = sgn;
        end else begin
            start = 1'b1; value_A = a; value_B = b; signed_op = sgn;
        end
        @(posedge clk); #1;
        start = 1'b0; s8_start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            lat++;
            @(posedge clk); #1;
            if (w8 ? s8_done : done) break;
        end
        q = w8 ? {24'd0, s8_lo} : lo;
        r = w8 ? {24'd0, s8_hi} : hi;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        #13;
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (divZero !== 1'b0) begin miscompares++; $display("FAIL reset_divzero: got %b expected 0", divZero); end
        vectors++; if (hi !== 32'd0)     begin miscompares++; $display("FAIL reset_hi: got %h expected 0", hi); end
        vectors++; if (lo !== 32'd0)     begin miscompares++; $display("FAIL reset_lo: got %h expected 0", lo); end
        // First start must be taken on the first rising edge after release.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; value_A = 32'd100; value_B = 32'd7; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL first_start_busy: got %b expected 1", busy); end
        n = 0;
        while (n < 100 && done !== 1'b1) begin n++; @(posedge clk); #1; end
        vectors++; if (n != 34) begin miscompares++; $display("FAIL first_start_latency: got %0d expected 34", n); end
    endtask

    task automatic test_directed();
        int lat;
        logic [31:0] q, r;
        run_op(0, 32'd100, 32'd7, 0, lat, q, r);
        vectors++; if (lat != 34)  begin miscompares++; $display("FAIL u100_7_latency: got %0d expected 34", lat); end
        vectors++; if (q !== 32'd14) begin miscompares++; $display("FAIL u100_7_lo: got %h expected %h", q, 32'd14); end
        vectors++; if (r !== 32'd2)  begin miscompares++; $display("FAIL u100_7_hi: got %h expected %h", r, 32'd2); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %b expected 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_done: got %b expected 0", busy); end
    endtask

    task automatic test_signed();
        int lat;
        logic [31:0] q, r;
        run_op(0, 32'hFFFF_FFF9, 32'h2, 1, lat, q, r);
        vectors++; if (q !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL s_m7_2_lo: got %h expected fffffffd", q); end
        vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL s_m7_2_hi: got %h expected ffffffff", r); end
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1, lat, q, r);
        vectors++; if (q !== 32'h8000_0000) begin miscompares++; $display("FAIL s_minneg_lo: got %h expected 80000000", q); end
        vectors++; if (r !== 32'h0)         begin miscompares++; $display("FAIL s_minneg_hi: got %h expected 0", r); end
        vectors++; if (divZero !== 1'b0)    begin miscompares++; $display("FAIL s_minneg_noflag: got %b expected 0", divZero); end
    endtask

    // Runs right after test_signed, so hi/lo still hold 0 / 0x80000000.
    task automatic test_div_zero();
        @(posedge clk); #1;
        start = 1'b1; value_A = 32'd55; value_B = 32'd0; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (divZero !== 1'b1) begin miscompares++; $display("FAIL dz_pulse: got %b expected 1", divZero); end
        vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL dz_no_done: got %b expected 0", done); end
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL dz_busy: got %b expected 0", busy); end
        vectors++; if (lo !== 32'h8000_0000) begin miscompares++; $display("FAIL dz_lo_kept: got %h expected 80000000", lo); end
        vectors++; if (hi !== 32'h0)     begin miscompares++; $display("FAIL dz_hi_kept: got %h expected 0", hi); end
        @(posedge clk); #1;
        vectors++; if (divZero !== 1'b0) begin miscompares++; $display("FAIL dz_one_cycle: got %b expected 0", divZero); end
    endtask

    task automatic test_abort();
        int ndone, n;
        logic [31:0] lo_before, hi_before;
        ndone = 0;
        lo_before = 32'h8000_0000; hi_before = 32'h0;
        @(posedge clk); #1;
        start = 1'b1; value_A = 32'd123456; value_B = 32'd77; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; if (done) ndone++; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
        vectors++; if (lo !== lo_before) begin miscompares++; $display("FAIL abort_lo_kept: got %h expected %h", lo, lo_before); end
        vectors++; if (hi !== hi_before) begin miscompares++; $display("FAIL abort_hi_kept: got %h expected %h", hi, hi_before); end
        start = 1'b1; value_A = 32'hFFFF_FFFF; value_B = 32'h10; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (n = 1; n <= 50; n++) begin @(posedge clk); #1; if (done) ndone++; end
        vectors++; if (ndone != 1) begin miscompares++; $display("FAIL abort_done_count: got %0d expected 1", ndone); end
        vectors++; if (lo !== 32'h0FFF_FFFF) begin miscompares++; $display("FAIL abort_next_lo: got %h expected 0fffffff", lo); end
        vectors++; if (hi !== 32'hF) begin miscompares++; $display("FAIL abort_next_hi: got %h expected f", hi); end
        // Abort in IDLE blocks a simultaneous start.
        start = 1'b1; abort = 1'b1; value_A = 32'd9; value_B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle_priority: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int ndone, n;
        ndone = 0;
        @(posedge clk); #1;
        start = 1'b1; value_A = 32'd5000; value_B = 32'd9; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        vectors++; if (lo !== 32'd0)  begin miscompares++; $display("FAIL rst_mid_lo: got %h expected 0", lo); end
        vectors++; if (hi !== 32'd0)  begin miscompares++; $display("FAIL rst_mid_hi: got %h expected 0", hi); end
        @(negedge clk);
        reset = 1'b1;
        for (n = 0; n < 45; n++) begin @(posedge clk); #1; if (done) ndone++; end
        vectors++; if (ndone != 0) begin miscompares++; $display("FAIL rst_mid_no_done: got %0d expected 0", ndone); end
    endtask

    task automatic test_hold_start();
        int n;
        @(posedge clk); #1;
        start = 1'b1; value_A = 32'd1000; value_B = 32'd7; signed_op = 1'b0;
        @(posedge clk); #1;
        value_A = 32'd55; value_B = 32'd3;
        n = 0;
        while (n < 100 && done !== 1'b1) begin
            n++;
            if (n == 20) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        vectors++; if (lo !== 32'd142) begin miscompares++; $display("FAIL hold_start_lo: got %h expected %h", lo, 32'd142); end
        vectors++; if (hi !== 32'd6)   begin miscompares++; $display("FAIL hold_start_hi: got %h expected %h", hi, 32'd6); end
    endtask

    task automatic test_w8();
        int lat;
        logic [31:0] q, r;
        logic [63:0] eq, er;
        logic [31:0] a, b;
        bit sgn;
        run_op(1, 32'd255, 32'd16, 0, lat, q, r);
        vectors++; if (lat != 10)    begin miscompares++; $display("FAIL w8_latency: got %0d expected 10", lat); end
        vectors++; if (q !== 32'd15) begin miscompares++; $display("FAIL w8_lo: got %h expected %h", q, 32'd15); end
        vectors++; if (r !== 32'd15) begin miscompares++; $display("FAIL w8_hi: got %h expected %h", r, 32'd15); end
        for (int i = 0; i < 60; i++) begin
            a = {24'd0, 8'($urandom)};
            b = {24'd0, 8'($urandom)};
            if (i % 7 == 0) a = 32'h80;
            if (i % 11 == 0) b = 32'hFF;
            if (b == 32'd0) b = 32'd1;
            sgn = bit'($urandom_range(0, 1));
            ref_div({32'd0, a}, {32'd0, b}, 8, sgn, eq, er);
            run_op(1, a, b, sgn, lat, q, r);
            vectors++; if (lat != 10) begin miscompares++; $display("FAIL w8_rand_latency: got %0d expected 10", lat); end
            vectors++; if (q !== eq[31:0]) begin miscompares++; $display("FAIL w8_rand_lo a=%h b=%h s=%0d: got %h expected %h", a, b, sgn, q, eq[31:0]); end
            vectors++; if (r !== er[31:0]) begin miscompares++; $display("FAIL w8_rand_hi a=%h b=%h s=%0d: got %h expected %h", a, b, sgn, r, er[31:0]); end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] q, r, a, b;
        logic [63:0] eq, er;
        bit sgn;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            case (i % 10)
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: a = 32'd0;
                4: b = 32'd1;
                5: b = a;
                default: ;
            endcase
            if (b == 32'd0) b = 32'd3;
            sgn = bit'($urandom_range(0, 1));
            ref_div({32'd0, a}, {32'd0, b}, 32, sgn, eq, er);
            run_op(0, a, b, sgn, lat, q, r);
            vectors++; if (lat != 34) begin miscompares++; $display("FAIL rand_latency: got %0d expected 34", lat); end
            vectors++; if (q !== eq[31:0]) begin miscompares++; $display("FAIL rand_lo a=%h b=%h s=%0d: got %h expected %h", a, b, sgn, q, eq[31:0]); end
            vectors++; if (r !== er[31:0]) begin miscompares++; $display("FAIL rand_hi a=%h b=%h s=%0d: got %h expected %h", a, b, sgn, r, er[31:0]); end
        end
    endtask

    initial begin
        start = 1'b0; signed_op = 1'b0; abort = 1'b0; value_A = '0; value_B = '0;
        s8_start = 1'b0; s8_signed_op = 1'b0; s8_abort = 1'b0; s8_A = '0; s8_B = '0;
        test_reset();
        test_directed();
        test_signed();
        test_div_zero();
        test_abort();
        test_reset_mid();
        test_hold_start();
        test_w8();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
